// File: rtl/jstepper.sv
// ============================================================================
//  Module      : jstepper
//  Description : CPU clock-phase generator and one-hot step ring counter.
//                A tick is four phases of DIV system clocks each. clk_e is
//                high in phases 0..2 and clk_s in phase 1 only, so clk_s is
//                always nested inside clk_e by at least DIV clocks on each side.
//                The step ring advances once per tick at the tick boundary
//                (phase 3, last divider count). At that boundary halt freezes
//                everything and restart forces the ring back to step 0.
//  Options     : JSTEPPER_SINGLE_STEP_EN - adds step_req and a sticky request
//                flag. Without a pending request every boundary behaves as a
//                halt, so each step_req gives exactly one tick.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jstepper #(
    parameter int NSTEPS = 6,
    parameter int DIV    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              restart,
`ifdef JSTEPPER_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic              clk_e,
    output logic              clk_s,
    output logic [NSTEPS-1:0] step,
    output logic              cycle_end
);

    // Divider counter width; a one-bit counter is kept even when DIV == 1.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0]     DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]     DIV_ONE    = CW'(1);
    localparam logic [NSTEPS-1:0] STEP_FIRST = {{(NSTEPS-1){1'b0}}, 1'b1};

    // Clock phase encoding within one CPU tick.
    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;
    localparam logic [1:0] PH_3 = 2'd3;

    logic [CW-1:0]     div_cnt_q, div_cnt_d;
    logic [1:0]        phase_q,   phase_d;
    logic [NSTEPS-1:0] step_q,    step_d;

    logic              div_last;
    logic              boundary;
    logic              stall;
    logic              advance;

    // Boundary detection: last system clock of phase 3 ends the tick.
    always_comb begin
        div_last = (div_cnt_q == DIV_LAST);
        boundary = div_last && (phase_q == PH_3);
    end

`ifdef JSTEPPER_SINGLE_STEP_EN
    logic flag_q, flag_d;

    // With no pending step request a boundary stalls exactly like halt.
    always_comb begin
        stall = halt || !flag_q;
    end

    // Sticky request flag: set by step_req, consumed by an advancing boundary
    // unless a fresh request lands on that same clock.
    always_comb begin
        flag_d = flag_q || step_req;
        if (advance && !step_req) begin
            flag_d = 1'b0;
        end
    end

    // Request flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end
`else
    // Free-running ring: only halt can stall a boundary.
    always_comb begin
        stall = halt;
    end
`endif

    // A boundary that is not stalled leaves the tick and moves the ring.
    always_comb begin
        advance = boundary && !stall;
    end

    // Next-state for divider, phase and step ring.
    always_comb begin
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        step_d    = step_q;
        if (!div_last) begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end else if (phase_q != PH_3) begin
            div_cnt_d = '0;
            phase_d   = phase_q + 2'd1;
        end else if (advance) begin
            // Tick boundary: restart wins over normal rotation. While stalled
            // the divider and phase are simply held at the boundary.
            div_cnt_d = '0;
            phase_d   = PH_0;
            if (restart) begin
                step_d = STEP_FIRST;
            end else begin
                step_d = {step_q[NSTEPS-2:0], step_q[NSTEPS-1]};
            end
        end
    end

    // State registers; reset abandons any partial tick immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            phase_q   <= PH_0;
            step_q    <= STEP_FIRST;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
        end
    end

    // Output decode. Phase 3 is also the halted phase, so the enable and set
    // strobes are naturally quiet while stalled.
    always_comb begin
        clk_e     = (phase_q == PH_0) || (phase_q == PH_1) || (phase_q == PH_2);
        clk_s     = (phase_q == PH_1);
        step      = step_q;
        cycle_end = advance && (restart || step_q[NSTEPS-1]);
    end

endmodule

`default_nettype wire
